fpmul_result_arbiter: RTL and testbench
=======================================

// Module: fpmul_result_arbiter
// PURPOSE
//  Downstream collector for the two FP32 multiplier cores (VHDL core, Verilog core) inside tl.
//  Captures each core's result on its done pulse and presents them one at a time on res/res_rdy.
//  res_rdy is one-hot: 01 = VHDL result, 10 = Verilog result, 00 = nothing valid.
//  Each result stays on the port for a fixed dwell, so a polling bench sees both results in sequence.
// PARAMETERS
//  SIZE         32  operand/result width (IEEE-754 single)
//  HOLD_CYCLES  4   cycles each result is presented, >=1
// PORTS
//  clk        in   1     rising-edge clock
//  rst        in   1     asynchronous, active-high reset
//  in_rdy     in   2     per-core enable from tl: bit0 VHDL core, bit1 Verilog core
//  vhdl_res   in   SIZE  VHDL core product
//  vhdl_done  in   1     1-cycle pulse, vhdl_res valid
//  vl_res     in   SIZE  Verilog core product
//  vl_done    in   1     1-cycle pulse, vl_res valid
//  res        out  SIZE  presented product
//  res_rdy    out  2     one-hot source of res; 00 = idle
//  overrun    out  1     1-cycle pulse: a done hit a source whose result was still pending/showing
// BEHAVIOUR
//  Reset: res=0, res_rdy=00, overrun=0, both pending flags=0, FSM=IDLE, dwell counter=0.
//  Capture: on an edge with x_done=1 and in_rdy bit for x =1, load buf_x and set pend_x.
//   done with its in_rdy bit=0 -> ignored. done while pend_x=1 or x showing -> buf_x overwritten,
//   overrun=1 for one cycle; a result already on res is not changed.
//  FSM states: IDLE, SHOW_VHDL, SHOW_VL. All outputs registered.
//   IDLE: pend_v (or vhdl_done this edge) -> SHOW_VHDL; else pend_l (or vl_done) -> SHOW_VL.
//    Bypass: done sampled on edge T gives res/res_rdy valid after edge T (latency 1 cycle).
//   SHOW_x: res=buf_x, res_rdy=x code, pend_x cleared on entry, counter counts 1..HOLD_CYCLES.
//    At count HOLD_CYCLES: other source pending -> SHOW_other directly (no idle gap);
//    else -> IDLE, res_rdy=00, res keeps last value.
//  Priority: both done on same edge, or both pending in IDLE -> VHDL first, Verilog next.
//  Abort: in_rdy==00 sampled on any edge -> FSM=IDLE, res_rdy=00, pend flags cleared next edge;
//   capture on that edge suppressed. Dropping one bit only clears that source's pending/showing.
//  Counter width $clog2(HOLD_CYCLES+1); wraps to 0 on every state entry.
//  rst asserted mid-show -> immediate return to reset values (asynchronous).
// CONFIGURATION
//  FPMUL_ARB_COMPARE_EN defined: adds output mismatch (1 bit, reset 0). When both sources
//   have been captured since the last IDLE-with-nothing-pending, mismatch=1 if buf_v!=buf_l,
//   held until the next capture or in_rdy==00. Exact bit compare; no NaN equivalence.
//  Not defined: no compare logic, no mismatch port; all other behaviour identical.
// TESTING
//  1 in_rdy=11, vhdl_done@T and vl_done@T+2, both 0x40800000 -> res_rdy=01 cycles T+1..T+4,
//    then 10 cycles T+5..T+8, res=0x40800000 throughout, then 00.
//  2 in_rdy=11, both done same edge (vhdl 0x3F800000, vl 0x3F800001) -> 01 first, 10 next;
//    with FPMUL_ARB_COMPARE_EN mismatch=1 after second capture.
//  3 in_rdy=01, vl_done pulses -> ignored; vhdl_done 0x40000000 -> only res_rdy=01, then 00.
//  4 vhdl_done twice 2 cycles apart while showing -> overrun pulse, current res unchanged,
//    second value shown after first dwell ends.
//  5 in_rdy drops to 00 during SHOW_VHDL with Verilog pending -> res_rdy=00 next edge, no SHOW_VL.
//  6 rst pulsed mid-SHOW_VL -> res=0, res_rdy=00 without waiting for clk edge.

Source files
------------

// File: rtl/fpmul_result_arbiter.sv
// ---------------------------------------------------------------------------
// fpmul_result_arbiter
//
// Purpose
//   Collects the products of the two FP32 multiplier cores (VHDL core and
//   Verilog core). Each product is captured on its core's done pulse and then
//   presented alone on res/res_rdy for HOLD_CYCLES cycles, so a polling
//   consumer sees both results one after the other.
//
//   res_rdy is one-hot: 2'b01 = VHDL result, 2'b10 = Verilog result,
//   2'b00 = nothing valid (res keeps the last value shown).
//
// Parameters
//   SIZE         result width (IEEE-754 single = 32)
//   HOLD_CYCLES  cycles each result is presented (>= 1)
//
// Ports
//   clk        in   1     rising-edge clock
//   rst        in   1     asynchronous, active-high reset
//   in_rdy     in   2     per-core enable: bit0 VHDL core, bit1 Verilog core
//   vhdl_res   in   SIZE  VHDL core product
//   vhdl_done  in   1     1-cycle pulse, vhdl_res valid
//   vl_res     in   SIZE  Verilog core product
//   vl_done    in   1     1-cycle pulse, vl_res valid
//   res        out  SIZE  presented product
//   res_rdy    out  2     one-hot source of res, 00 = idle
//   overrun    out  1     1-cycle pulse: a done hit a source whose previous
//                         result was still pending or being shown
//   mismatch   out  1     (only with FPMUL_ARB_COMPARE_EN) both sources
//                         captured in this session and their bits differ
//
// Configuration
//   FPMUL_ARB_COMPARE_EN  when defined, adds the mismatch output and the
//                         bit-exact comparison of the two captured products.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module fpmul_result_arbiter #(
  parameter int SIZE        = 32,
  parameter int HOLD_CYCLES = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [1:0]      in_rdy,
  input  logic [SIZE-1:0] vhdl_res,
  input  logic            vhdl_done,
  input  logic [SIZE-1:0] vl_res,
  input  logic            vl_done,
  output logic [SIZE-1:0] res,
  output logic [1:0]      res_rdy,
  output logic            overrun
`ifdef FPMUL_ARB_COMPARE_EN
  ,
  output logic            mismatch
`endif
);

  // Dwell counter must be able to hold the value HOLD_CYCLES itself.
  localparam int CW = $clog2(HOLD_CYCLES + 1);
  localparam logic [CW-1:0] HOLD_VAL = CW'(HOLD_CYCLES);

  localparam logic [1:0] RDY_NONE = 2'b00;
  localparam logic [1:0] RDY_VHDL = 2'b01;
  localparam logic [1:0] RDY_VL   = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_SHOW_VHDL = 2'd1,
    ST_SHOW_VL   = 2'd2
  } state_t;

  // -------------------------------------------------------------------------
  // State and registered outputs
  // -------------------------------------------------------------------------
  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic [SIZE-1:0] r_buf_v;
  logic [SIZE-1:0] r_buf_l;
  logic            r_pend_v;
  logic            r_pend_l;
  logic [SIZE-1:0] r_res;
  logic [1:0]      r_res_rdy;
  logic            r_overrun;

  // -------------------------------------------------------------------------
  // Per-edge decode
  // -------------------------------------------------------------------------
  logic            w_abort;     // both cores disabled: drop everything
  logic            w_cap_v;     // VHDL product accepted on this edge
  logic            w_cap_l;     // Verilog product accepted on this edge
  logic [SIZE-1:0] w_buf_v_nx;  // VHDL buffer as it will be after this edge
  logic [SIZE-1:0] w_buf_l_nx;  // Verilog buffer as it will be after this edge
  logic            w_pv;        // VHDL result waiting after this edge
  logic            w_pl;        // Verilog result waiting after this edge
  logic            w_ovr;       // a capture landed on an unconsumed result
  logic [CW-1:0]   w_cnt_inc;
  logic            w_dwell_end;

  // NOTE: every signal assigned in an always_comb gets a default at the top of
  // the block, so no path can leave it unassigned and infer a latch.
  always_comb begin
    w_abort     = (in_rdy == 2'b00);
    // A done whose enable bit is low is ignored; this also suppresses capture
    // on an abort edge since both enable bits are then low.
    w_cap_v     = vhdl_done & in_rdy[0];
    w_cap_l     = vl_done   & in_rdy[1];
    w_buf_v_nx  = w_cap_v ? vhdl_res : r_buf_v;
    w_buf_l_nx  = w_cap_l ? vl_res   : r_buf_l;
    // Dropping one enable bit discards that source's pending result.
    w_pv        = w_cap_v | (r_pend_v & in_rdy[0]);
    w_pl        = w_cap_l | (r_pend_l & in_rdy[1]);
    w_ovr       = (w_cap_v & (r_pend_v | (r_state == ST_SHOW_VHDL))) |
                  (w_cap_l & (r_pend_l | (r_state == ST_SHOW_VL)));
    w_cnt_inc   = r_cnt + CW'(1);
    w_dwell_end = (w_cnt_inc == HOLD_VAL);
  end

  // -------------------------------------------------------------------------
  // Capture buffers, pending flags and presentation FSM
  // -------------------------------------------------------------------------
  // NOTE: sequential state is written with non-blocking assignments only, so
  // every register samples the pre-edge values of its neighbours.
  // NOTE: the product buffers are plain registers and are reset with the rest
  // of the state; they are never read as stale data after reset because the
  // pending flags are cleared alongside them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_buf_v   <= '0;
      r_buf_l   <= '0;
      r_pend_v  <= 1'b0;
      r_pend_l  <= 1'b0;
      r_res     <= '0;
      r_res_rdy <= RDY_NONE;
      r_overrun <= 1'b0;
    end else begin
      r_overrun <= w_ovr;
      if (w_cap_v) r_buf_v <= vhdl_res;
      if (w_cap_l) r_buf_l <= vl_res;

      // Default: pending flags follow capture/enable; a state entry below
      // overrides the flag of the source it starts showing.
      r_pend_v <= w_pv;
      r_pend_l <= w_pl;

      if (w_abort) begin
        r_state   <= ST_IDLE;
        r_cnt     <= '0;
        r_res_rdy <= RDY_NONE;
        r_pend_v  <= 1'b0;
        r_pend_l  <= 1'b0;
      end else begin
        unique case (r_state)
          // Bypass: a done sampled on this edge is presented right after it.
          // VHDL wins when both are available.
          ST_IDLE: begin
            if (w_pv) begin
              r_state   <= ST_SHOW_VHDL;
              r_cnt     <= '0;
              r_res     <= w_buf_v_nx;
              r_res_rdy <= RDY_VHDL;
              r_pend_v  <= 1'b0;
            end else if (w_pl) begin
              r_state   <= ST_SHOW_VL;
              r_cnt     <= '0;
              r_res     <= w_buf_l_nx;
              r_res_rdy <= RDY_VL;
              r_pend_l  <= 1'b0;
            end
          end

          // A dwell ends when the count reaches HOLD_CYCLES or when the
          // source's enable bit is dropped. The other source is then shown
          // without an idle gap if it has something waiting.
          ST_SHOW_VHDL: begin
            if (w_dwell_end || !in_rdy[0]) begin
              if (w_pl) begin
                r_state   <= ST_SHOW_VL;
                r_cnt     <= '0;
                r_res     <= w_buf_l_nx;
                r_res_rdy <= RDY_VL;
                r_pend_l  <= 1'b0;
              end else begin
                r_state   <= ST_IDLE;
                r_cnt     <= '0;
                r_res_rdy <= RDY_NONE;
              end
            end else begin
              r_cnt <= w_cnt_inc;
            end
          end

          ST_SHOW_VL: begin
            if (w_dwell_end || !in_rdy[1]) begin
              if (w_pv) begin
                r_state   <= ST_SHOW_VHDL;
                r_cnt     <= '0;
                r_res     <= w_buf_v_nx;
                r_res_rdy <= RDY_VHDL;
                r_pend_v  <= 1'b0;
              end else begin
                r_state   <= ST_IDLE;
                r_cnt     <= '0;
                r_res_rdy <= RDY_NONE;
              end
            end else begin
              r_cnt <= w_cnt_inc;
            end
          end

          default: begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_res_rdy <= RDY_NONE;
          end
        endcase
      end
    end
  end

  assign res     = r_res;
  assign res_rdy = r_res_rdy;
  assign overrun = r_overrun;

`ifdef FPMUL_ARB_COMPARE_EN
  // -------------------------------------------------------------------------
  // Optional cross-check of the two products
  // -------------------------------------------------------------------------
  // A "session" starts after an idle cycle with nothing pending. Once both
  // sources have been captured within the session, mismatch reports whether
  // their bit patterns differ; it is re-evaluated on every capture and
  // cleared by an abort.
  logic r_got_v;
  logic r_got_l;
  logic r_mismatch;
  logic w_got_v_nx;
  logic w_got_l_nx;

  always_comb begin
    w_got_v_nx = r_got_v | w_cap_v;
    w_got_l_nx = r_got_l | w_cap_l;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_got_v    <= 1'b0;
      r_got_l    <= 1'b0;
      r_mismatch <= 1'b0;
    end else if (w_abort) begin
      r_got_v    <= 1'b0;
      r_got_l    <= 1'b0;
      r_mismatch <= 1'b0;
    end else if (w_cap_v || w_cap_l) begin
      r_got_v    <= w_got_v_nx;
      r_got_l    <= w_got_l_nx;
      r_mismatch <= w_got_v_nx & w_got_l_nx & (w_buf_v_nx != w_buf_l_nx);
    end else if (r_state == ST_IDLE && !r_pend_v && !r_pend_l) begin
      r_got_v <= 1'b0;
      r_got_l <= 1'b0;
    end
  end

  assign mismatch = r_mismatch;
`endif

endmodule

// File: tb/tb_fpmul_result_arbiter.sv
`timescale 1ns/1ps

module tb_fpmul_result_arbiter;

  localparam int SIZE = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic [1:0]      in_rdy;
  logic [SIZE-1:0] vhdl_res;
  logic            vhdl_done;
  logic [SIZE-1:0] vl_res;
  logic            vl_done;
  logic [SIZE-1:0] res;
  logic [1:0]      res_rdy;
  logic            overrun;
`ifdef FPMUL_ARB_COMPARE_EN
  logic            mismatch;
`endif

  int n_cmp = 0;
  int n_err = 0;

  fpmul_result_arbiter #(.SIZE(SIZE), .HOLD_CYCLES(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_rdy    (in_rdy),
    .vhdl_res  (vhdl_res),
    .vhdl_done (vhdl_done),
    .vl_res    (vl_res),
    .vl_done   (vl_done),
    .res       (res),
    .res_rdy   (res_rdy),
    .overrun   (overrun)
`ifdef FPMUL_ARB_COMPARE_EN
    ,
    .mismatch  (mismatch)
`endif
  );

  always #5 clk = ~clk;

  // Advance n rising edges and land 1 ns after the last one.
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst       = 1'b1;
    in_rdy    = 2'b11;
    vhdl_res  = '0;
    vhdl_done = 1'b0;
    vl_res    = '0;
    vl_done   = 1'b0;

    // ---- reset state ------------------------------------------------------
    #12;
    check("rst_res",     res,     32'h0);
    check("rst_res_rdy", res_rdy, 32'h0);
    check("rst_overrun", overrun, 32'h0);
    rst = 1'b0;
    step(2);
    check("idle_res_rdy", res_rdy, 32'h0);

    // ---- 1: VHDL at T, Verilog at T+2, same value --------------------------
    vhdl_res = 32'h4080_0000; vhdl_done = 1'b1;
    step(1);                                   // edge T
    vhdl_done = 1'b0;
    check("t1_rdy_T",  res_rdy, 32'h1);
    check("t1_res_T",  res,     32'h4080_0000);
    step(1);                                   // T+1
    vl_res = 32'h4080_0000; vl_done = 1'b1;
    step(1);                                   // T+2
    vl_done = 1'b0;
    check("t1_rdy_T2", res_rdy, 32'h1);
    check("t1_ovr_T2", overrun, 32'h0);
    step(1);                                   // T+3
    check("t1_rdy_T3", res_rdy, 32'h1);
    step(1);                                   // T+4
    check("t1_rdy_T4", res_rdy, 32'h2);
    check("t1_res_T4", res,     32'h4080_0000);
    step(3);                                   // T+7
    check("t1_rdy_T7", res_rdy, 32'h2);
    step(1);                                   // T+8
    check("t1_rdy_T8", res_rdy, 32'h0);
    check("t1_res_T8", res,     32'h4080_0000);
    step(1);

    // ---- 2: both done on the same edge -------------------------------------
    vhdl_res = 32'h3F80_0000; vhdl_done = 1'b1;
    vl_res   = 32'h3F80_0001; vl_done   = 1'b1;
    step(1);                                   // E
    vhdl_done = 1'b0; vl_done = 1'b0;
    check("t2_rdy_E",  res_rdy, 32'h1);
    check("t2_res_E",  res,     32'h3F80_0000);
    check("t2_ovr_E",  overrun, 32'h0);
`ifdef FPMUL_ARB_COMPARE_EN
    check("t2_mismatch", mismatch, 32'h1);
`endif
    step(3);                                   // E+3
    check("t2_rdy_E3", res_rdy, 32'h1);
    step(1);                                   // E+4
    check("t2_rdy_E4", res_rdy, 32'h2);
    check("t2_res_E4", res,     32'h3F80_0001);
    step(4);                                   // E+8
    check("t2_rdy_E8", res_rdy, 32'h0);
    check("t2_res_E8", res,     32'h3F80_0001);
    step(1);

    // ---- 3: Verilog core disabled ------------------------------------------
    in_rdy = 2'b01;
    step(1);
    vl_res = 32'h1234_5678; vl_done = 1'b1;
    step(1);
    vl_done = 1'b0;
    check("t3_vl_ignored_rdy", res_rdy, 32'h0);
    check("t3_vl_ignored_ovr", overrun, 32'h0);
    check("t3_vl_ignored_res", res,     32'h3F80_0001);
    vhdl_res = 32'h4000_0000; vhdl_done = 1'b1;
    step(1);                                   // E
    vhdl_done = 1'b0;
    check("t3_rdy_E",  res_rdy, 32'h1);
    check("t3_res_E",  res,     32'h4000_0000);
    step(3);                                   // E+3
    check("t3_rdy_E3", res_rdy, 32'h1);
    step(1);                                   // E+4
    check("t3_rdy_E4", res_rdy, 32'h0);
    step(1);
    check("t3_rdy_E5", res_rdy, 32'h0);

    // ---- 4: VHDL overrun while showing -------------------------------------
    in_rdy = 2'b11;
    step(1);
    vhdl_res = 32'h4100_0000; vhdl_done = 1'b1;
    step(1);                                   // E
    vhdl_done = 1'b0;
    check("t4_rdy_E",  res_rdy, 32'h1);
    check("t4_ovr_E",  overrun, 32'h0);
    step(1);                                   // E+1
    vhdl_res = 32'h4110_0000; vhdl_done = 1'b1;
    step(1);                                   // E+2
    vhdl_done = 1'b0;
    check("t4_ovr_E2", overrun, 32'h1);
    check("t4_res_E2", res,     32'h4100_0000);
    check("t4_rdy_E2", res_rdy, 32'h1);
    step(1);                                   // E+3
    check("t4_ovr_E3", overrun, 32'h0);
    check("t4_res_E3", res,     32'h4100_0000);
    step(1);                                   // E+4: dwell over, idle
    check("t4_rdy_E4", res_rdy, 32'h0);
    check("t4_res_E4", res,     32'h4100_0000);
    step(1);                                   // E+5: second value shown
    check("t4_rdy_E5", res_rdy, 32'h1);
    check("t4_res_E5", res,     32'h4110_0000);
    step(4);                                   // E+9
    check("t4_rdy_E9", res_rdy, 32'h0);
    step(1);

    // ---- 5: abort during SHOW_VHDL with Verilog pending ---------------------
    vhdl_res = 32'h4040_0000; vhdl_done = 1'b1;
    vl_res   = 32'h40A0_0000; vl_done   = 1'b1;
    step(1);                                   // E
    vhdl_done = 1'b0; vl_done = 1'b0;
    check("t5_rdy_E",  res_rdy, 32'h1);
    check("t5_res_E",  res,     32'h4040_0000);
    step(1);                                   // E+1
    in_rdy = 2'b00;
    step(1);                                   // E+2: abort sampled
    check("t5_rdy_abort", res_rdy, 32'h0);
`ifdef FPMUL_ARB_COMPARE_EN
    check("t5_mismatch_abort", mismatch, 32'h0);
`endif
    in_rdy = 2'b11;
    step(1);
    check("t5_no_vl_1", res_rdy, 32'h0);
    step(5);
    check("t5_no_vl_2", res_rdy, 32'h0);
    check("t5_res_kept", res,    32'h4040_0000);

    // ---- 6: asynchronous reset mid SHOW_VL ----------------------------------
    vl_res = 32'h40E0_0000; vl_done = 1'b1;
    step(1);
    vl_done = 1'b0;
    check("t6_rdy_show", res_rdy, 32'h2);
    check("t6_res_show", res,     32'h40E0_0000);
    step(1);
    #2;                                        // well away from any edge
    rst = 1'b1;
    #1;
    check("t6_async_res", res,     32'h0);
    check("t6_async_rdy", res_rdy, 32'h0);
    check("t6_async_ovr", overrun, 32'h0);
    #3;
    rst = 1'b0;
    step(2);
    check("t6_after_rdy", res_rdy, 32'h0);
    check("t6_after_res", res,     32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
